// File: rtl/fifo_rd_seq_checker_pkg.sv
// Shared definitions for the FIFO example read-side sequence checker:
// data width and checker state encoding.
package fifo_rd_seq_checker_pkg;

    localparam int DATA_W = 12;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         kill,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/fifo_rd_seq_checker.sv
// Locks onto the 0, STEP, 2*STEP ... ramp read back from the FIFO example and
// reports per-word mismatches, a saturating error count and frame completions.
module fifo_rd_seq_checker
    import fifo_rd_seq_checker_pkg::*;
#(
    parameter logic [DATA_W-1:0] STACK_WIDTH = 12'd5,
    parameter logic [DATA_W-1:0] STEP        = 12'd10,
    parameter logic [3:0]        LOSS_THRESH = 4'd3,
    parameter int                CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 kill,
    input  logic                 rd_valid,
    input  logic [DATA_W-1:0]    rd_data,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic [DATA_W-1:0]    exp_data,
    output logic                 err_pulse,
    output logic                 sticky_err,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    localparam logic [DATA_W-1:0] LAST_IDX = STACK_WIDTH - 12'd1;
    // A one-word frame wraps straight back to index 0 right after the syncing word.
    localparam logic [DATA_W-1:0] SYNC_IDX = (STACK_WIDTH == 12'd1) ? 12'd0 : 12'd1;
    localparam logic [DATA_W-1:0] SYNC_EXP = (STACK_WIDTH == 12'd1) ? 12'd0 : STEP;

    state_t                r_state;
    logic [DATA_W-1:0]     r_index;
    logic [DATA_W-1:0]     r_exp;
    logic [3:0]            r_miss;
    logic                  r_err_pulse;
    logic                  r_frame_done;
    logic                  r_sticky;
    logic [CNT_WIDTH-1:0]  r_frame_cnt;

    state_t                w_state_nxt;
    logic [DATA_W-1:0]     w_index_nxt;
    logic [DATA_W-1:0]     w_exp_nxt;
    logic [3:0]            w_miss_nxt;
    logic                  w_err_ev;
    logic                  w_frame_ev;
    logic                  w_mismatch;
    logic [4:0]            w_miss_inc;

    assign w_mismatch = (rd_data != r_exp);
    assign w_miss_inc = {1'b0, r_miss} + 5'd1;

    // NOTE: every variable gets a default at the top so no path leaves a latch behind.
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_exp_nxt   = r_exp;
        w_miss_nxt  = r_miss;
        w_err_ev    = 1'b0;
        w_frame_ev  = 1'b0;

        case (r_state)
            ST_SYNC: begin
                if (rd_valid && (rd_data == '0)) begin
                    w_state_nxt = ST_LOCK;
                    w_index_nxt = SYNC_IDX;
                    w_exp_nxt   = SYNC_EXP;
                    w_miss_nxt  = '0;
                end
            end
            ST_LOCK: begin
                if (rd_valid) begin
                    if (w_mismatch) begin
                        w_err_ev   = 1'b1;
                        w_miss_nxt = w_miss_inc[3:0];
                    end else begin
                        w_miss_nxt = '0;
                    end

                    // Loss of lock pre-empts the frame report for the same word.
                    if (w_mismatch && (w_miss_inc >= {1'b0, LOSS_THRESH})) begin
                        w_state_nxt = ST_SYNC;
                        w_index_nxt = '0;
                        w_exp_nxt   = '0;
                        w_miss_nxt  = '0;
                    end else if (r_index == LAST_IDX) begin
                        w_frame_ev  = 1'b1;
                        w_index_nxt = '0;
                        w_exp_nxt   = '0;
                    end else begin
                        w_index_nxt = r_index + 12'd1;
                        w_exp_nxt   = r_exp + STEP;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
                w_index_nxt = '0;
                w_exp_nxt   = '0;
                w_miss_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            r_state      <= ST_SYNC;
            r_index      <= '0;
            r_exp        <= '0;
            r_miss       <= '0;
            r_err_pulse  <= 1'b0;
            r_frame_done <= 1'b0;
            r_sticky     <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_exp        <= w_exp_nxt;
            r_miss       <= w_miss_nxt;
            r_err_pulse  <= w_err_ev;
            r_frame_done <= w_frame_ev;
            if (clear_cnt) begin
                r_sticky    <= 1'b0;
                r_frame_cnt <= '0;
            end else begin
                if (w_err_ev) begin
                    r_sticky <= 1'b1;
                end
                if (w_frame_ev) begin
                    r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_WIDTH)
    ) u_err_cnt (
        .clk  (clk),
        .kill (kill),
        .inc  (w_err_ev),
        .clr  (clear_cnt),
        .q    (err_cnt)
    );

    assign locked     = (r_state == ST_LOCK);
    assign exp_data   = r_exp;
    assign err_pulse  = r_err_pulse;
    assign sticky_err = r_sticky;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_fifo_rd_seq_checker.sv
// Bench for fifo_rd_seq_checker: directed vector table, hand-written corner
// sequences, and random traffic scored against a ramp-position reference model.
module tb_fifo_rd_seq_checker;

    localparam int SW     = 5;
    localparam int STEPV  = 10;
    localparam int THRESH = 3;
    localparam int CMAX   = 65535;

    logic        clk;
    logic        kill;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic        clear_cnt;
    logic        locked;
    logic [11:0] exp_data;
    logic        err_pulse;
    logic        sticky_err;
    logic [15:0] err_cnt;
    logic        frame_done;
    logic [15:0] frame_cnt;

    logic        v4;
    logic [11:0] d4;
    logic        c4;
    logic        locked4;
    logic [11:0] exp4;
    logic        ep4;
    logic        st4;
    logic [3:0]  ec4;
    logic        fd4;
    logic [3:0]  fc4;

    fifo_rd_seq_checker dut (
        .clk        (clk),
        .kill       (kill),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .clear_cnt  (clear_cnt),
        .locked     (locked),
        .exp_data   (exp_data),
        .err_pulse  (err_pulse),
        .sticky_err (sticky_err),
        .err_cnt    (err_cnt),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    fifo_rd_seq_checker #(
        .CNT_WIDTH (4)
    ) dut4 (
        .clk        (clk),
        .kill       (kill),
        .rd_valid   (v4),
        .rd_data    (d4),
        .clear_cnt  (c4),
        .locked     (locked4),
        .exp_data   (exp4),
        .err_pulse  (ep4),
        .sticky_err (st4),
        .err_cnt    (ec4),
        .frame_done (fd4),
        .frame_cnt  (fc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference model: ramp position k, expected word is k*STEP mod 4096.
    int m_locked, m_k, m_miss, m_err, m_frames, m_sticky, m_ep, m_fd;

    task automatic mdl_reset();
        m_locked = 0; m_k = 0; m_miss = 0; m_err = 0;
        m_frames = 0; m_sticky = 0; m_ep = 0; m_fd = 0;
    endtask

    function automatic int mdl_exp();
        return (m_k * STEPV) % 4096;
    endfunction

    task automatic mdl_step(input logic v, input logic [11:0] d, input logic c);
        int bad;
        m_ep = 0;
        m_fd = 0;
        if (v) begin
            if (m_locked == 0) begin
                if (d == 12'd0) begin
                    m_locked = 1;
                    m_k      = 1 % SW;
                    m_miss   = 0;
                end
            end else begin
                bad = (int'(d) != mdl_exp()) ? 1 : 0;
                if (bad != 0) begin
                    m_ep   = 1;
                    m_err  = (m_err < CMAX) ? m_err + 1 : CMAX;
                    m_miss = m_miss + 1;
                end else begin
                    m_miss = 0;
                end
                if (bad != 0 && m_miss >= THRESH) begin
                    m_locked = 0;
                    m_k      = 0;
                    m_miss   = 0;
                end else if (m_k == SW - 1) begin
                    m_fd     = 1;
                    m_frames = (m_frames + 1) % 65536;
                    m_k      = 0;
                end else begin
                    m_k = m_k + 1;
                end
            end
        end
        if (c) begin
            m_err = 0; m_frames = 0; m_sticky = 0;
        end else if (m_ep != 0) begin
            m_sticky = 1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " locked"},     32'(locked),     32'(m_locked));
        check({tag, " exp_data"},   32'(exp_data),   32'(mdl_exp()));
        check({tag, " err_pulse"},  32'(err_pulse),  32'(m_ep));
        check({tag, " sticky_err"}, 32'(sticky_err), 32'(m_sticky));
        check({tag, " err_cnt"},    32'(err_cnt),    32'(m_err));
        check({tag, " frame_done"}, 32'(frame_done), 32'(m_fd));
        check({tag, " frame_cnt"},  32'(frame_cnt),  32'(m_frames));
    endtask

    task automatic cycle(input logic v, input logic [11:0] d, input logic c);
        rd_valid  = v;
        rd_data   = d;
        clear_cnt = c;
        @(posedge clk);
        mdl_step(v, d, c);
        #1;
        rd_valid  = 1'b0;
        clear_cnt = 1'b0;
    endtask

    task automatic cycle4(input logic v, input logic [11:0] d, input logic c);
        v4 = v;
        d4 = d;
        c4 = c;
        @(posedge clk);
        #1;
        v4 = 1'b0;
        c4 = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [11:0] d;
        logic        c;
        logic        lk;
        logic [11:0] ex;
        logic        ep;
        logic        st;
        logic [15:0] ec;
        logic        fd;
        logic [15:0] fc;
    } vec_t;

    function automatic vec_t mk(input logic v, input int d, input logic lk, input int ex,
                                input logic ep, input logic st, input int ec,
                                input logic fd, input int fc);
        vec_t r;
        r.v = v; r.d = 12'(d); r.c = 1'b0; r.lk = lk; r.ex = 12'(ex);
        r.ep = ep; r.st = st; r.ec = 16'(ec); r.fd = fd; r.fc = 16'(fc);
        return r;
    endfunction

    vec_t vecs[12];

    initial begin
        kill = 1'b1; rd_valid = 1'b0; rd_data = '0; clear_cnt = 1'b0;
        v4 = 1'b0; d4 = '0; c4 = 1'b0;
        mdl_reset();

        // Clean ramp with a frame wrap, then one corrupted word (21) in a locked frame.
        vecs[0]  = mk(1,  0, 1, 10, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 10, 1, 20, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 20, 1, 30, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 30, 1, 40, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 40, 1,  0, 0, 0, 0, 1, 1);
        vecs[5]  = mk(1,  0, 1, 10, 0, 0, 0, 0, 1);
        vecs[6]  = mk(1, 10, 1, 20, 0, 0, 0, 0, 1);
        vecs[7]  = mk(1, 21, 1, 30, 1, 1, 1, 0, 1);
        vecs[8]  = mk(1, 30, 1, 40, 0, 1, 1, 0, 1);
        vecs[9]  = mk(1, 40, 1,  0, 0, 1, 1, 1, 2);
        vecs[10] = mk(1,  0, 1, 10, 0, 1, 1, 0, 2);
        vecs[11] = mk(0, 55, 1, 10, 0, 1, 1, 0, 2);

        repeat (2) @(posedge clk);
        #1;
        check("reset locked",   32'(locked),    32'd0);
        check("reset exp_data", 32'(exp_data),  32'd0);
        check("reset err_cnt",  32'(err_cnt),   32'd0);
        check("reset frame_cnt", 32'(frame_cnt), 32'd0);
        kill = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].c);
            check($sformatf("vec%0d locked", i),     32'(locked),     32'(vecs[i].lk));
            check($sformatf("vec%0d exp_data", i),   32'(exp_data),   32'(vecs[i].ex));
            check($sformatf("vec%0d err_pulse", i),  32'(err_pulse),  32'(vecs[i].ep));
            check($sformatf("vec%0d sticky_err", i), 32'(sticky_err), 32'(vecs[i].st));
            check($sformatf("vec%0d err_cnt", i),    32'(err_cnt),    32'(vecs[i].ec));
            check($sformatf("vec%0d frame_done", i), 32'(frame_done), 32'(vecs[i].fd));
            check($sformatf("vec%0d frame_cnt", i),  32'(frame_cnt),  32'(vecs[i].fc));
        end

        // Three consecutive misses: the third lands on the last index, loses lock, no frame.
        cycle(0, 0, 1);
        check("clr err_cnt",    32'(err_cnt),    32'd0);
        check("clr frame_cnt",  32'(frame_cnt),  32'd0);
        check("clr sticky",     32'(sticky_err), 32'd0);
        check("clr keeps lock", 32'(locked),     32'd1);
        cycle(1, 10, 0);
        cycle(1, 7, 0);
        cycle(1, 7, 0);
        check("loss2 locked", 32'(locked), 32'd1);
        cycle(1, 7, 0);
        check("loss3 locked",     32'(locked),     32'd0);
        check("loss3 err_cnt",    32'(err_cnt),    32'd3);
        check("loss3 err_pulse",  32'(err_pulse),  32'd1);
        check("loss3 frame_done", 32'(frame_done), 32'd0);
        check("loss3 exp_data",   32'(exp_data),   32'd0);
        cycle(1, 20, 0);
        check("sync ignore err_pulse", 32'(err_pulse), 32'd0);
        check("sync ignore err_cnt",   32'(err_cnt),   32'd3);
        cycle(1, 0, 0);
        check("relock locked",   32'(locked),   32'd1);
        check("relock exp_data", 32'(exp_data), 32'd10);

        // Mid-stream start after reset: 30 and 40 are ignored until a 0 arrives.
        @(posedge clk); #3; kill = 1'b1; #2; kill = 1'b0;
        mdl_reset();
        cycle(1, 30, 0);
        cycle(1, 40, 0);
        check("midstream locked",  32'(locked),  32'd0);
        check("midstream err_cnt", 32'(err_cnt), 32'd0);
        cycle(1, 0, 0);
        check("midstream lock", 32'(locked), 32'd1);
        cycle(1, 10, 0);
        check("midstream match err_pulse", 32'(err_pulse), 32'd0);
        check_model("midstream");

        // Asynchronous kill between edges clears everything before the next edge.
        cycle(1, 20, 0);
        cycle(1, 99, 0);
        #3;
        kill = 1'b1;
        #1;
        check("kill locked",     32'(locked),     32'd0);
        check("kill exp_data",   32'(exp_data),   32'd0);
        check("kill err_pulse",  32'(err_pulse),  32'd0);
        check("kill sticky_err", 32'(sticky_err), 32'd0);
        check("kill err_cnt",    32'(err_cnt),    32'd0);
        check("kill frame_cnt",  32'(frame_cnt),  32'd0);
        @(posedge clk); #1;
        check("kill held frame_done", 32'(frame_done), 32'd0);
        kill = 1'b0;
        mdl_reset();
        cycle(1, 0, 0);
        check("kill relock", 32'(locked), 32'd1);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            int          r;
            logic        v;
            logic [11:0] d;
            logic        c;
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 6)      d = 12'(mdl_exp());
            else if (r < 7) d = 12'd0;
            else            d = 12'($urandom_range(0, 4095));
            c = ($urandom_range(0, 40) == 0);
            cycle(v, d, c);
            check_model($sformatf("rand%0d", i));
        end

        // Narrow counter: 21 errors saturate at 15; clear beats a same-cycle error.
        for (int rnd = 0; rnd < 7; rnd++) begin
            cycle4(1, 0, 0);
            for (int j = 0; j < 3; j++) cycle4(1, 5, 0);
            if (rnd == 2) check("sat ec4 after 9", 32'(ec4), 32'd9);
        end
        check("sat ec4",      32'(ec4),     32'd15);
        check("sat locked4",  32'(locked4), 32'd0);
        cycle4(1, 0, 0);
        check("sat relock4", 32'(locked4), 32'd1);
        cycle4(1, 5, 1);
        check("clr+err ec4",  32'(ec4), 32'd0);
        check("clr+err ep4",  32'(ep4), 32'd1);
        check("clr+err st4",  32'(st4), 32'd0);
        cycle4(0, 0, 0);
        check("pulse drop ep4", 32'(ep4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
